// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: receive end of the START|DATA(LSB first)|STOP serial link.
// The line is synchronised, each bit is sampled at 1/4, 1/2 and 3/4 of the bit
// period and resolved by a 2-of-3 vote, and finished words land in a one-entry
// holding register drained by a ready/valid handshake.
module uart_rx_sampler #(
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_FREQUENCY = 48000000,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_uart,
  input  logic                 rx_rdy,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int CLKS_PER_BIT = (CLK_FREQUENCY + BAUD_RATE - 1) / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] Q1       = CW'(CLKS_PER_BIT / 4);
  localparam logic [CW-1:0] Q2       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] Q3       = CW'((3 * CLKS_PER_BIT) / 4);
  localparam logic [CW-1:0] DEC      = CW'((3 * CLKS_PER_BIT) / 4 + 1);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_rate_chk
      $error("uart_rx_sampler: CLKS_PER_BIT must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_width_chk
      $error("uart_rx_sampler: DATA_BITS must be within 5..9");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q, rx_prev_q;
  // Start detection is armed only once rx_s and its history both reflect the
  // real line, so a line already low at reset release is not taken as an edge.
  logic [2:0]           arm_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 s1_q, s1_d, s2_q, s2_d, vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic                 valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic                 dec, wrap;

  assign dec  = (cnt_q == DEC);
  assign wrap = (cnt_q == LAST);

  // Two-flop synchroniser plus one cycle of history for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= '0;
    end else begin
      rx_meta_q <= rx_uart;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      arm_q     <= {arm_q[1:0], 1'b1};
    end
  end

  // Next-state: bit timing, 3-point sampling, frame sequencing and handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    vote_d  = vote_q;
    shift_d = shift_q;
    valid_d = valid_q;
    data_d  = data_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (state_q == START || state_q == DATA || state_q == STOP) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (cnt_q == Q1) s1_d = rx_s_q;
      if (cnt_q == Q2) s2_d = rx_s_q;
      if (cnt_q == Q3) vote_d = (s1_q & s2_q) | (s1_q & rx_s_q) | (s2_q & rx_s_q);
    end

    if (valid_q && rx_rdy) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arm_q[2] && rx_prev_q && !rx_s_q) begin
          cnt_d   = CW'(1);
          state_d = START;
        end
      end
      START: begin
        if (dec && vote_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (wrap) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (dec) shift_d = {vote_q, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (dec) begin
          cnt_d = '0;
          if (vote_q) begin
            // Leave before the stop bit ends so a back-to-back start is caught.
            if (!valid_q || rx_rdy) begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end else begin
              ov_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sampling and holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      vote_q  <= 1'b0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      vote_q  <= vote_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx_valid     = valid_q;
  assign rx_data      = data_q;
  assign rx_frame_err = fe_q;
  assign rx_overrun   = ov_q;
endmodule
